// File: rtl/divider_top.sv
// Sequential radix-2 restoring divider, data_out = {remainder, quotient}; DIV_SIGNED_EN selects two's complement.
// Latency: start-to-done is N+2 cycles for every operand pair, including divide-by-zero.
// Backpressure: none; start is accepted only in IDLE and ignored (not queued) while busy.
module divider_top #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   data_dividend,
    input  logic [N-1:0]   data_divisor,
    output logic [2*N-1:0] data_out,
    output logic           done,
    output logic           busy,
    output logic           div_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N:0]     rem_q;
    logic [N-1:0]   quo_q;
    logic [N-1:0]   dvs_q;
    logic [N-1:0]   dvd_q;
    logic [CW-1:0]  count;
    logic           dz_q;

    logic [2*N:0]   rq_sh;
    logic [N:0]     rem_sh;
    logic [N+1:0]   trial;
    logic           trial_ok;
    logic [N:0]     rem_nxt;
    logic [N-1:0]   quo_nxt;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;

`ifdef DIV_SIGNED_EN
    logic neg_dd;
    logic neg_dv;

    function automatic logic [N-1:0] mag(input logic [N-1:0] x);
        return x[N-1] ? -x : x;
    endfunction
`endif

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ITER;
            end
            ITER: if (count == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step; the extra trial bit is the borrow that decides restore.
    always_comb begin
        rq_sh    = {rem_q, quo_q} << 1;
        rem_sh   = rq_sh[2*N:N];
        trial    = {1'b0, rem_sh} - {2'b0, dvs_q};
        trial_ok = ~trial[N+1];
        rem_nxt  = trial_ok ? trial[N:0] : rem_sh;
        quo_nxt  = {rq_sh[N-1:1], trial_ok};
    end

    always_comb begin
`ifdef DIV_SIGNED_EN
        q_fix = (neg_dd ^ neg_dv) ? -quo_q : quo_q;
        r_fix = neg_dd ? -rem_q[N-1:0] : rem_q[N-1:0];
`else
        q_fix = quo_q;
        r_fix = rem_q[N-1:0];
`endif
        if (dz_q) begin
            q_fix = '1;
            r_fix = dvd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            dz_q     <= 1'b0;
            data_out <= '0;
            div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_dd   <= 1'b0;
            neg_dv   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    rem_q <= '0;
                    count <= CW'(N);
                    dvd_q <= data_dividend;
                    dz_q  <= (data_divisor == '0);
`ifdef DIV_SIGNED_EN
                    quo_q  <= mag(data_dividend);
                    dvs_q  <= mag(data_divisor);
                    neg_dd <= data_dividend[N-1];
                    neg_dv <= data_divisor[N-1];
`else
                    quo_q  <= data_dividend;
                    dvs_q  <= data_divisor;
`endif
                end
                ITER: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    count <= count - CW'(1);
                end
                FIX: begin
                    data_out <= {r_fix, q_fix};
                    div_zero <= dz_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_top.sv
// Directed-vector bench for divider_top: latency, result packing, done/busy timing, reset abort.
module tb_divider_top;

    localparam int N   = 16;
    localparam int LIM = 60;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   data_dividend;
    logic [N-1:0]   data_divisor;
    logic [2*N-1:0] data_out;
    logic           done;
    logic           busy;
    logic           div_zero;

    int vectors    = 0;
    int miscompares = 0;

    divider_top #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_dividend (data_dividend),
        .data_divisor  (data_divisor),
        .data_out      (data_out),
        .done          (done),
        .busy          (busy),
        .div_zero      (div_zero)
    );

    always #5 clk = ~clk;

    // Pulses start for one edge, then reports cycles until done, the result and the done width.
    task automatic run_op(input logic [N-1:0] dd, input logic [N-1:0] dv,
                          output int lat, output logic [2*N-1:0] res,
                          output logic dz, output int width);
        @(posedge clk); #1;
        start = 1'b1; data_dividend = dd; data_divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
        data_dividend = N'($urandom); data_divisor = N'($urandom);
        lat = 1;
        while (!done && lat < LIM) begin
            @(posedge clk); #1;
            lat++;
        end
        res   = data_out;
        dz    = div_zero;
        width = 0;
        while (done && width < 4) begin
            width++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; data_dividend = 16'd5; data_divisor = 16'd1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat, w; logic [2*N-1:0] res; logic dz;
        run_op(16'd100, 16'd7, lat, res, dz, w);
        vectors++; if (lat !== N + 2) begin miscompares++; $display("FAIL u100_7_latency: got %0d expected %0d", lat, N + 2); end
        vectors++; if (res !== 32'h0002_000E) begin miscompares++; $display("FAIL u100_7_data: got %h expected 0002000e", res); end
        vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL u100_7_div_zero: got %b expected 0", dz); end
        vectors++; if (w !== 1) begin miscompares++; $display("FAIL u100_7_done_width: got %0d expected 1", w); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL u100_7_busy_after: got %b expected 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (data_out !== 32'h0002_000E) begin miscompares++; $display("FAIL u100_7_hold: got %h expected 0002000e", data_out); end
    endtask

    task automatic test_div_zero();
        int lat, w; logic [2*N-1:0] res; logic dz;
        run_op(16'd1234, 16'd0, lat, res, dz, w);
        vectors++; if (lat !== N + 2) begin miscompares++; $display("FAIL dz_latency: got %0d expected %0d", lat, N + 2); end
        vectors++; if (res !== 32'h04D2_FFFF) begin miscompares++; $display("FAIL dz_data: got %h expected 04d2ffff", res); end
        vectors++; if (dz !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b expected 1", dz); end
        vectors++; if (w !== 1) begin miscompares++; $display("FAIL dz_done_width: got %0d expected 1", w); end
        vectors++; if (div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_flag_held: got %b expected 1", div_zero); end
    endtask

    task automatic test_signed();
        logic [N-1:0]   dds [3] = '{16'hFF9C, 16'h0064, 16'h8000};
        logic [N-1:0]   dvs [3] = '{16'h0007, 16'hFFF9, 16'hFFFF};
`ifdef DIV_SIGNED_EN
        logic [2*N-1:0] exps[3] = '{32'hFFFE_FFF2, 32'h0002_FFF2, 32'h0000_8000};
`else
        logic [2*N-1:0] exps[3] = '{32'h0000_2484, 32'h0064_0000, 32'h8000_0000};
`endif
        int lat, w; logic [2*N-1:0] res; logic dz;
        for (int i = 0; i < 3; i++) begin
            run_op(dds[i], dvs[i], lat, res, dz, w);
            vectors++; if (res !== exps[i]) begin miscompares++; $display("FAIL sign_vec%0d_data: got %h expected %h", i, res, exps[i]); end
            vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL sign_vec%0d_div_zero: got %b expected 0", i, dz); end
            vectors++; if (lat !== N + 2) begin miscompares++; $display("FAIL sign_vec%0d_latency: got %0d expected %0d", i, lat, N + 2); end
        end
    endtask

    task automatic test_max();
        int lat, w; logic [2*N-1:0] res; logic dz;
        run_op(16'hFFFF, 16'h0001, lat, res, dz, w);
        vectors++; if (res !== 32'h0000_FFFF) begin miscompares++; $display("FAIL max_data: got %h expected 0000ffff", res); end
        vectors++; if (lat !== N + 2) begin miscompares++; $display("FAIL max_latency: got %0d expected %0d", lat, N + 2); end
    endtask

    task automatic test_ignore_start();
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; data_dividend = 16'd50; data_divisor = 16'd5;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (cyc < 4) begin @(posedge clk); #1; cyc++; end
        start = 1'b1; data_dividend = 16'd9; data_divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0; cyc++;
        while (!done && cyc < LIM) begin @(posedge clk); #1; cyc++; end
        vectors++; if (cyc !== N + 2) begin miscompares++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, N + 2); end
        vectors++; if (data_out !== 32'h0000_000A) begin miscompares++; $display("FAIL ignore_data: got %h expected 0000000a", data_out); end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_not_queued: busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int cyc, lat, w; logic [2*N-1:0] res; logic dz; logic saw_done;
        saw_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; data_dividend = 16'd50; data_divisor = 16'd5;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (cyc < 4) begin @(posedge clk); #1; cyc++; saw_done |= done; end
        start = 1'b1; data_dividend = 16'd9; data_divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0; cyc++; saw_done |= done;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL abort_data_out: got %h expected 0", data_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
        vectors++; if (div_zero !== 1'b0) begin miscompares++; $display("FAIL abort_div_zero: got %b expected 0", div_zero); end
        repeat (N + 4) begin @(posedge clk); #1; saw_done |= done; end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got %b expected 0", saw_done); end
        run_op(16'd9, 16'd3, lat, res, dz, w);
        vectors++; if (res !== 32'h0000_0003) begin miscompares++; $display("FAIL abort_next_data: got %h expected 00000003", res); end
        vectors++; if (lat !== N + 2) begin miscompares++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, N + 2); end
    endtask

    task automatic test_back_to_back();
        int cyc, t1, t2; logic [2*N-1:0] r1, r2;
        t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        @(posedge clk); #1;
        start = 1'b1; data_dividend = 16'hFFFF; data_divisor = 16'h0001;
        @(posedge clk); #1;
        cyc = 1; data_dividend = 16'd200; data_divisor = 16'd10;
        while (t2 < 0 && cyc < 4 * LIM) begin
            if (done) begin
                if (t1 < 0) begin t1 = cyc; r1 = data_out; end
                else begin t2 = cyc; r2 = data_out; end
            end
            if (t2 < 0) begin @(posedge clk); #1; cyc++; end
        end
        start = 1'b0;
        vectors++; if (t1 !== N + 2) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected %0d", t1, N + 2); end
        vectors++; if (t2 - t1 !== N + 3) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, N + 3); end
        vectors++; if (r1 !== 32'h0000_FFFF) begin miscompares++; $display("FAIL b2b_first_data: got %h expected 0000ffff", r1); end
        vectors++; if (r2 !== 32'h0000_0014) begin miscompares++; $display("FAIL b2b_second_data: got %h expected 00000014", r2); end
        repeat (N + 6) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_dividend = '0; data_divisor = '0;
        test_reset();
        test_unsigned();
        test_div_zero();
        test_signed();
        test_max();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
